// File: rtl/pill_pkg.sv
// -----------------------------------------------------------------------------
// pill_pkg
// Shared definitions for the pill batch counter:
//   state_e      - run FSM state encodings (3-bit, visible on out_state)
//   MODE_AUTO    - count one pill per clock while filling
//   MODE_SENSOR  - count one pill per in_pill_pulse strobe while filling
//   DEF_CNT_W    - default width of bottle/pill counters and targets
//   DEF_TOT_W    - default width of the lifetime total-pill counter
// -----------------------------------------------------------------------------
package pill_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_FILL = 3'b001,
    S_SWAP = 3'b010,
    S_DONE = 3'b011,
    S_ERR  = 3'b100
  } state_e;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_SENSOR = 1'b1;

  localparam int DEF_CNT_W = 6;
  localparam int DEF_TOT_W = 12;

endpackage : pill_pkg

// File: rtl/pill_batch_counter_if.sv
// -----------------------------------------------------------------------------
// pill_batch_counter_if
// Control/status bundle between the line controller and pill_batch_counter.
//   master modport : drives the in_* controls, observes the out_* status
//   slave  modport : the counter itself
// Clock and reset are not part of the bundle.
// -----------------------------------------------------------------------------
interface pill_batch_counter_if #(
  parameter int CNT_W = 6,
  parameter int TOT_W = 12
) ();

  logic             in_start;
  logic             in_clear;
  logic             in_suspend;
  logic             in_mode;
  logic             in_pill_pulse;
  logic             in_bottle_ready;
  logic [CNT_W-1:0] in_target_bottle_num;
  logic [CNT_W-1:0] in_target_pill_num;

  logic [CNT_W-1:0] out_bottle_num;
  logic [CNT_W-1:0] out_pill_num;
  logic [TOT_W-1:0] out_total_pill;
  logic             out_next_bottle;
  logic             out_busy;
  logic             out_finish;
  logic             out_error;
  logic [2:0]       out_state;

  modport master (
    output in_start, in_clear, in_suspend, in_mode, in_pill_pulse,
           in_bottle_ready, in_target_bottle_num, in_target_pill_num,
    input  out_bottle_num, out_pill_num, out_total_pill, out_next_bottle,
           out_busy, out_finish, out_error, out_state
  );

  modport slave (
    input  in_start, in_clear, in_suspend, in_mode, in_pill_pulse,
           in_bottle_ready, in_target_bottle_num, in_target_pill_num,
    output out_bottle_num, out_pill_num, out_total_pill, out_next_bottle,
           out_busy, out_finish, out_error, out_state
  );

endinterface : pill_batch_counter_if

// File: rtl/pill_event_gen.sv
// -----------------------------------------------------------------------------
// pill_event_gen
// Qualified pill-event strobe. A pill counts only while filling and not
// suspended: every cycle in auto mode, or on the sensor strobe in sensor mode.
//   i_state      : current run FSM state
//   i_mode       : MODE_AUTO / MODE_SENSOR
//   i_pill_pulse : one-cycle pill-detected strobe
//   i_suspend    : pause request
//   o_pill_event : one pill to be counted on the next edge
// -----------------------------------------------------------------------------
module pill_event_gen
  import pill_pkg::*;
(
  input  state_e i_state,
  input  logic   i_mode,
  input  logic   i_pill_pulse,
  input  logic   i_suspend,
  output logic   o_pill_event
);

  assign o_pill_event = (i_state == S_FILL) && !i_suspend &&
                        ((i_mode == MODE_AUTO) || i_pill_pulse);

endmodule : pill_event_gen

// File: rtl/pill_batch_counter.sv
// -----------------------------------------------------------------------------
// pill_batch_counter
// Batch run controller for the bottling line: latches bottle/pill targets at
// start, counts pills into the current bottle, handshakes bottle swaps with the
// conveyor and keeps a saturating lifetime pill total.
//   in_clk, in_rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)      : start/clear/suspend/mode/pulse/ready controls, targets,
//                      and registered counts, next-bottle pulse, busy/finish/
//                      error flags and the raw state encoding
// Every output comes straight from a register (or decodes only the state
// register), so there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module pill_batch_counter
  import pill_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TOT_W = DEF_TOT_W
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  pill_batch_counter_if.slave   bus
);

  state_e           r_state, w_next_state;
  logic [CNT_W-1:0] r_bottle, w_bottle;
  logic [CNT_W-1:0] r_pill, w_pill;
  logic [CNT_W-1:0] r_tgt_bottle, w_tgt_bottle;
  logic [CNT_W-1:0] r_tgt_pill, w_tgt_pill;
  logic [TOT_W-1:0] r_total, w_total;
  logic             r_next_bottle, w_next_bottle;
  logic             w_pill_event;
  logic             w_last_pill;
  logic             w_last_bottle;

  pill_event_gen u_event_gen (
    .i_state      (r_state),
    .i_mode       (bus.in_mode),
    .i_pill_pulse (bus.in_pill_pulse),
    .i_suspend    (bus.in_suspend),
    .o_pill_event (w_pill_event)
  );

  // Targets are at least 1 once in S_FILL, so tgt-1 never wraps here.
  assign w_last_pill   = (r_pill == (r_tgt_pill - CNT_W'(1)));
  assign w_last_bottle = ((r_bottle + CNT_W'(1)) == r_tgt_bottle);

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned; that is what keeps this block free of latches.
  always_comb begin
    w_next_state  = r_state;
    w_bottle      = r_bottle;
    w_pill        = r_pill;
    w_tgt_bottle  = r_tgt_bottle;
    w_tgt_pill    = r_tgt_pill;
    w_total       = r_total;
    w_next_bottle = 1'b0;

    if (bus.in_clear) begin
      w_next_state = S_IDLE;
      w_bottle     = '0;
      w_pill       = '0;
      w_total      = '0;
    end else if (!bus.in_suspend) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_start) begin
            w_tgt_bottle = bus.in_target_bottle_num;
            w_tgt_pill   = bus.in_target_pill_num;
            w_bottle     = '0;
            w_pill       = '0;
            w_next_state = ((bus.in_target_bottle_num == '0) ||
                            (bus.in_target_pill_num == '0)) ? S_ERR : S_FILL;
          end
        end
        S_FILL: begin
          if (w_pill_event) begin
            w_total = (r_total == '1) ? r_total : r_total + TOT_W'(1);
            if (w_last_pill) begin
              w_pill        = '0;
              w_bottle      = r_bottle + CNT_W'(1);
              w_next_bottle = 1'b1;
              w_next_state  = w_last_bottle ? S_DONE : S_SWAP;
            end else begin
              w_pill = r_pill + CNT_W'(1);
            end
          end
        end
        S_SWAP: begin
          if (bus.in_bottle_ready) w_next_state = S_FILL;
        end
        S_DONE, S_ERR: ;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_bottle      <= '0;
      r_pill        <= '0;
      r_tgt_bottle  <= '0;
      r_tgt_pill    <= '0;
      r_total       <= '0;
      r_next_bottle <= 1'b0;
    end else begin
      r_bottle      <= w_bottle;
      r_pill        <= w_pill;
      r_tgt_bottle  <= w_tgt_bottle;
      r_tgt_pill    <= w_tgt_pill;
      r_total       <= w_total;
      r_next_bottle <= w_next_bottle;
    end
  end

  assign bus.out_bottle_num  = r_bottle;
  assign bus.out_pill_num    = r_pill;
  assign bus.out_total_pill  = r_total;
  assign bus.out_next_bottle = r_next_bottle;
  assign bus.out_busy        = (r_state == S_FILL) || (r_state == S_SWAP);
  assign bus.out_finish      = (r_state == S_DONE);
  assign bus.out_error       = (r_state == S_ERR);
  assign bus.out_state       = r_state;

endmodule : pill_batch_counter

// File: tb/tb_pill_batch_counter.sv
// -----------------------------------------------------------------------------
// tb_pill_batch_counter
// Drives two counters in lockstep (12-bit and 4-bit lifetime totals) from one
// stimulus stream. A behavioural model predicts the post-edge outputs for each
// cycle and queues them; a separate monitor pops and compares after each edge.
// Directed scenarios add end-of-run and timing checks on top.
// -----------------------------------------------------------------------------
module tb_pill_batch_counter;
  import pill_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pill_batch_counter_if #(.CNT_W(6), .TOT_W(12)) bus   ();
  pill_batch_counter_if #(.CNT_W(6), .TOT_W(4))  bus_s ();

  pill_batch_counter #(.CNT_W(6), .TOT_W(12)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .bus(bus.slave));
  pill_batch_counter #(.CNT_W(6), .TOT_W(4)) dut_sat (
    .in_clk(clk), .in_rst_n(rst_n), .bus(bus_s.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- stimulus variables ----------------
  bit s_start, s_clear, s_susp, s_mode, s_pulse, s_ready;
  int s_tb, s_tp;

  // ---------------- reference model ----------------
  // States: 0 idle, 1 filling, 2 waiting for bottle, 3 done, 4 error.
  int m_state, m_bottle, m_pill, m_total, m_total4, m_tgtb, m_tgtp;
  bit m_nb;

  typedef struct {
    int st; int bottle; int pill; int total; int total4; bit nb;
  } snap_t;
  snap_t sb[$];

  task automatic model_reset();
    m_state = 0; m_bottle = 0; m_pill = 0; m_total = 0; m_total4 = 0;
    m_tgtb = 0; m_tgtp = 0; m_nb = 0;
  endtask

  task automatic model_step();
    m_nb = 0;
    if (s_clear) begin
      m_state = 0; m_bottle = 0; m_pill = 0; m_total = 0; m_total4 = 0;
    end else if (!s_susp) begin
      case (m_state)
        0: if (s_start) begin
             m_tgtb = s_tb; m_tgtp = s_tp; m_bottle = 0; m_pill = 0;
             m_state = (s_tb == 0 || s_tp == 0) ? 4 : 1;
           end
        1: if (s_mode == 1'b0 || s_pulse) begin
             m_total  = (m_total  < 4095) ? m_total  + 1 : 4095;
             m_total4 = (m_total4 < 15)   ? m_total4 + 1 : 15;
             m_pill++;
             if (m_pill == m_tgtp) begin
               m_pill = 0;
               m_bottle++;
               m_nb = 1;
               m_state = (m_bottle == m_tgtb) ? 3 : 2;
             end
           end
        2: if (s_ready) m_state = 1;
        default: ;
      endcase
    end
  endtask

  task automatic set_idle();
    s_start = 0; s_clear = 0; s_susp = 0; s_mode = 0; s_pulse = 0; s_ready = 0;
    s_tb = 0; s_tp = 0;
  endtask

  // Apply one cycle of stimulus at the falling edge and queue the prediction.
  task automatic drive();
    snap_t e;
    @(negedge clk);
    bus.in_start   = s_start;   bus_s.in_start   = s_start;
    bus.in_clear   = s_clear;   bus_s.in_clear   = s_clear;
    bus.in_suspend = s_susp;    bus_s.in_suspend = s_susp;
    bus.in_mode    = s_mode;    bus_s.in_mode    = s_mode;
    bus.in_pill_pulse   = s_pulse; bus_s.in_pill_pulse   = s_pulse;
    bus.in_bottle_ready = s_ready; bus_s.in_bottle_ready = s_ready;
    bus.in_target_bottle_num = 6'(s_tb); bus_s.in_target_bottle_num = 6'(s_tb);
    bus.in_target_pill_num   = 6'(s_tp); bus_s.in_target_pill_num   = 6'(s_tp);
    model_step();
    e.st = m_state; e.bottle = m_bottle; e.pill = m_pill;
    e.total = m_total; e.total4 = m_total4; e.nb = m_nb;
    sb.push_back(e);
  endtask

  task automatic clear_run();
    set_idle(); s_clear = 1; drive(); s_clear = 0;
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  int pulse_cyc[$];

  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.out_next_bottle === 1'b1) pulse_cyc.push_back(cyc);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state",       32'(bus.out_state),       32'(e.st));
        check("bottle",      32'(bus.out_bottle_num),  32'(e.bottle));
        check("pill",        32'(bus.out_pill_num),    32'(e.pill));
        check("total",       32'(bus.out_total_pill),  32'(e.total));
        check("next_bottle", 32'(bus.out_next_bottle), 32'(e.nb));
        check("busy",        32'(bus.out_busy),   32'(e.st == 1 || e.st == 2));
        check("finish",      32'(bus.out_finish), 32'(e.st == 3));
        check("error",       32'(bus.out_error),  32'(e.st == 4));
        check("sat_state",   32'(bus_s.out_state),       32'(e.st));
        check("sat_bottle",  32'(bus_s.out_bottle_num),  32'(e.bottle));
        check("sat_pill",    32'(bus_s.out_pill_num),    32'(e.pill));
        check("sat_total",   32'(bus_s.out_total_pill),  32'(e.total4));
        check("sat_next",    32'(bus_s.out_next_bottle), 32'(e.nb));
      end
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    int last_p;
    set_idle();
    model_reset();
    rst_n = 1'b0;
    drive();
    sb.delete();
    #3;
    check("rst_state",  32'(bus.out_state),       32'd0);
    check("rst_bottle", 32'(bus.out_bottle_num),  32'd0);
    check("rst_pill",   32'(bus.out_pill_num),    32'd0);
    check("rst_total",  32'(bus.out_total_pill),  32'd0);
    check("rst_flags",  32'({bus.out_next_bottle, bus.out_busy, bus.out_finish, bus.out_error}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Auto mode 3x4, conveyor always ready, targets scrambled mid-run.
    s_mode = 0; s_ready = 1; s_tb = 3; s_tp = 4; s_start = 1;
    drive();
    pulse_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      s_start = 1'($urandom_range(0, 1));
      s_tb = $urandom_range(1, 63);
      s_tp = $urandom_range(1, 63);
      drive();
    end
    check("auto_state",  32'(bus.out_state),      32'(S_DONE));
    check("auto_bottle", 32'(bus.out_bottle_num), 32'd3);
    check("auto_pill",   32'(bus.out_pill_num),   32'd0);
    check("auto_total",  32'(bus.out_total_pill), 32'd12);
    check("auto_finish", 32'(bus.out_finish),     32'd1);
    check("auto_pulses", 32'(pulse_cyc.size()),   32'd3);
    for (int i = 1; i < pulse_cyc.size(); i++)
      check("auto_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd5);
    clear_run();

    // Sensor mode 2x3, pulse every 4th cycle, ready 10 cycles after a bottle.
    s_mode = 1; s_tb = 2; s_tp = 3; s_start = 1;
    drive();
    s_start = 0;
    last_p = 0;
    for (int c = 1; c < 90; c++) begin
      s_pulse = (c % 4 == 3);
      s_ready = (c - last_p >= 10);
      drive();
      if (m_nb) last_p = c;
    end
    check("sensor_total",  32'(bus.out_total_pill), 32'd6);
    check("sensor_bottle", 32'(bus.out_bottle_num), 32'd2);
    check("sensor_finish", 32'(bus.out_finish),     32'd1);
    clear_run();

    // Suspend at pill=2 for 7 cycles.
    s_mode = 0; s_ready = 1; s_tb = 2; s_tp = 8; s_start = 1;
    drive();
    s_start = 0;
    for (int i = 0; i < 10 && m_pill != 2; i++) drive();
    s_susp = 1;
    for (int i = 0; i < 7; i++) begin
      drive();
      @(posedge clk); #2;
      check("susp_pill", 32'(bus.out_pill_num),    32'd2);
      check("susp_nb",   32'(bus.out_next_bottle), 32'd0);
    end
    s_susp = 0;
    drive();
    @(posedge clk); #2;
    check("resume_pill", 32'(bus.out_pill_num), 32'd3);
    clear_run();

    // Zero pill target goes to error; clear recovers.
    s_tb = 3; s_tp = 0; s_start = 1;
    drive();
    s_start = 0;
    @(posedge clk); #2;
    check("zero_state", 32'(bus.out_state),      32'(S_ERR));
    check("zero_error", 32'(bus.out_error),      32'd1);
    check("zero_pill",  32'(bus.out_pill_num),   32'd0);
    check("zero_bot",   32'(bus.out_bottle_num), 32'd0);
    clear_run();
    @(posedge clk); #2;
    check("zclr_state", 32'(bus.out_state), 32'(S_IDLE));
    check("zclr_error", 32'(bus.out_error), 32'd0);

    // Clear while filling.
    s_mode = 0; s_ready = 1; s_tb = 3; s_tp = 5; s_start = 1;
    drive();
    s_start = 0;
    repeat (3) drive();
    clear_run();
    @(posedge clk); #2;
    check("fclr_state", 32'(bus.out_state),      32'(S_IDLE));
    check("fclr_pill",  32'(bus.out_pill_num),   32'd0);
    check("fclr_total", 32'(bus.out_total_pill), 32'd0);

    // Asynchronous reset mid-run, checked before any clock edge.
    s_mode = 0; s_ready = 1; s_tb = 3; s_tp = 5; s_start = 1;
    drive();
    s_start = 0;
    repeat (4) drive();
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(bus.out_state),      32'd0);
    check("arst_pill",  32'(bus.out_pill_num),   32'd0);
    check("arst_total", 32'(bus.out_total_pill), 32'd0);
    check("arst_busy",  32'(bus.out_busy),       32'd0);
    sb.delete();
    model_reset();
    set_idle();
    drive();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the 4-bit total: 5 bottles x 4 pills.
    s_mode = 0; s_ready = 1; s_tb = 5; s_tp = 4; s_start = 1;
    drive();
    s_start = 0;
    repeat (30) drive();
    check("sat_total_end",  32'(bus_s.out_total_pill), 32'd15);
    check("sat_bottle_end", 32'(bus_s.out_bottle_num), 32'd5);
    check("full_total_end", 32'(bus.out_total_pill),   32'd20);
    check("sat_finish_end", 32'(bus_s.out_finish),     32'd1);
    clear_run();

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      s_clear = ($urandom_range(0, 99) < 3);
      s_susp  = ($urandom_range(0, 99) < 12);
      s_start = ($urandom_range(0, 99) < 20);
      s_mode  = 1'($urandom_range(0, 1));
      s_pulse = 1'($urandom_range(0, 1));
      s_ready = ($urandom_range(0, 99) < 30);
      s_tb    = $urandom_range(0, 4);
      s_tp    = $urandom_range(0, 5);
      drive();
    end

    set_idle();
    drive();
    @(posedge clk); #3;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pill_batch_counter

// File: doc/pill_batch_counter.md
Name: pill_batch_counter

Overview:
- Parametrised successor to the bottling-line pill/bottle counter.
- Owns its own run FSM. Latches targets at start.
- Counts pills either one per clock (auto) or from a sensor pulse (sensor mode).
- Handshakes each bottle swap with the conveyor and reports done/error status to the display and controller logic.

Parameters:
- CNT_W, 6: width of bottle/pill counters and targets.
- TOT_W, 12: width of the lifetime total-pill counter (saturating).

Ports:
- in_clk  input  1  system clock, rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_start  input  1  start request, sampled only in S_IDLE.
- in_clear  input  1  synchronous return to S_IDLE from any state.
- in_suspend  input  1  1 = pause; counters and FSM hold.
- in_mode  input  1  0 = auto (one pill per clock), 1 = sensor (count in_pill_pulse).
- in_pill_pulse  input  1  one-cycle pill-detected strobe (sensor mode only).
- in_bottle_ready  input  1  conveyor reports a fresh bottle in place.
- in_target_bottle_num  input  CNT_W  bottles per batch.
- in_target_pill_num  input  CNT_W  pills per bottle.
- out_bottle_num  output  CNT_W  completed bottles this batch.
- out_pill_num  output  CNT_W  pills in the current bottle.
- out_total_pill  output  TOT_W  pills since reset/clear; saturates at all-ones.
- out_next_bottle  output  1  one-cycle pulse when a bottle completes.
- out_busy  output  1  high in S_FILL and S_SWAP.
- out_finish  output  1  level, high in S_DONE.
- out_error  output  1  level, high in S_ERR.
- out_state  output  3  current FSM state encoding.

Behaviour:
- Reset (in_rst_n low, async): state S_IDLE. All counters 0, all flags 0, latched targets 0.
- States:
  - S_IDLE=000, S_FILL=001, S_SWAP=010, S_DONE=011, S_ERR=100.
  - Registered outputs, no combinational in->out paths.
- Priority each cycle: in_clear > in_suspend > normal operation.
- in_clear (any state):
  - Next state S_IDLE.
  - bottle, pill and total counts go to 0; flags go to 0.
- S_IDLE:
  - in_start latches both targets.
  - If either target is 0, go to S_ERR; else go to S_FILL with bottle and pill counts 0.
  - in_start outside S_IDLE is ignored.
- Target inputs are ignored after latching; mid-run changes have no effect.
- Pill event (evaluated in S_FILL only, and only with in_suspend=0):
  - Auto mode: every cycle.
  - Sensor mode: in_pill_pulse=1.
- On a pill event in S_FILL:
  - If pill==tgt_pill-1: pill<=0, bottle<=bottle+1, out_next_bottle=1 next cycle. Then go to S_DONE if bottle+1==tgt_bottle, else go to S_SWAP.
  - Otherwise: pill<=pill+1.
  - Either way: total<=total+1, saturating.
- tgt_pill=1: every pill event completes a bottle.
- S_SWAP:
  - Go to S_FILL on in_bottle_ready=1 with in_suspend=0.
  - Pill pulses here are ignored and not counted.
- S_DONE: out_finish=1 and counts are held until in_clear.
- S_ERR: out_error=1 until in_clear.
- Suspend:
  - Freezes all counters and the state.
  - out_next_bottle is forced 0.
  - Resume continues exactly where the run paused.
- Latency:
  - Counters update on the edge after the event.
  - out_next_bottle is high for exactly one cycle per completed bottle, in the same cycle the incremented bottle count is visible.
- Widths:
  - All comparisons are CNT_W unsigned.
  - Targets up to 2^CNT_W-1 are legal.

Decomposition:
- Shared package pill_pkg holds:
  - state encodings S_IDLE..S_ERR (3-bit);
  - mode constants MODE_AUTO=0, MODE_SENSOR=1;
  - default widths CNT_W=6, TOT_W=12.
- One sub-module: pill_event_gen, which produces the qualified pill-event strobe from state, in_mode, in_pill_pulse and in_suspend.

Test Plan:
- Auto mode, targets bottles=3, pills=4, bottle_ready tied high:
  - 3 out_next_bottle pulses, spaced 5 cycles (4 fill + 1 swap).
  - Ends in S_DONE with bottle=3, pill=0, total=12, finish=1.
- Sensor mode, bottles=2, pills=3, pulses every 4th cycle, bottle_ready delayed 10 cycles after each pulse:
  - Pulses during S_SWAP are not counted.
  - Finish with total=6.
- Suspend:
  - Raise suspend at pill=2 for 7 cycles in auto mode.
  - Counts frozen at 2 throughout; resumes to 3 on the first cycle after release; no next_bottle pulse while suspended.
- Zero target:
  - Start with pills=0: S_ERR with error=1 next cycle, counters 0.
  - in_clear returns to S_IDLE and clears error.
- Mid-run changes:
  - Change target inputs mid-run: no effect on completion point.
  - Assert in_clear in S_FILL: S_IDLE and all counts 0 next cycle.
  - Async reset mid-run: outputs 0 immediately, without waiting for a clock edge.
- Saturation:
  - TOT_W=4 build, bottles=5, pills=4 (20 pills): out_total_pill sticks at 15 while per-bottle counting continues normally.
